// File: rtl/sevenseg_scroll_display.sv
// Multiplexed N-digit seven-segment driver fed by a right-entry scrolling ASCII buffer.
// Optional blink feature is enabled by defining SEVENSEG_BLINK_EN.
module sevenseg_scroll_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  input  logic                  clear,
`ifdef SEVENSEG_BLINK_EN
  input  logic                  blink,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BKSP  = 8'h08;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] DIGIT0 = NUM_DIGITS'(1);

  // seg[6:0] ordered g..a, active-low
  function automatic logic [6:0] decode(input logic [7:0] c);
    logic [6:0] s;
    case (c)
      8'h30: s = 7'b1000000;
      8'h31: s = 7'b1111001;
      8'h32: s = 7'b0100100;
      8'h33: s = 7'b0110000;
      8'h34: s = 7'b0011001;
      8'h35: s = 7'b0010010;
      8'h36: s = 7'b0000010;
      8'h37: s = 7'b1111000;
      8'h38: s = 7'b0000000;
      8'h39: s = 7'b0010000;
      8'h41, 8'h61: s = 7'b0001000;
      8'h42, 8'h62: s = 7'b0000011;
      8'h43, 8'h63: s = 7'b1000110;
      8'h44, 8'h64: s = 7'b0100001;
      8'h45, 8'h65: s = 7'b0000110;
      8'h46, 8'h66: s = 7'b0001110;
      8'h48, 8'h68: s = 7'b0001001;
      8'h4C, 8'h6C: s = 7'b1000111;
      8'h50, 8'h70: s = 7'b0001100;
      8'h55, 8'h75: s = 7'b1000001;
      8'h2D:        s = 7'b0111111;
      8'h20:        s = SEG_OFF;
      default:      s = 7'b0110110;
    endcase
    return s;
  endfunction

  logic [NUM_DIGITS-1:0][7:0] chars_q, chars_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       slot_end;
  logic                       in_blank;
  logic                       blink_off;

  always_comb begin
    chars_d = chars_q;
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) chars_d[i] = SPACE;
    end else if (key_valid) begin
      if (key_code == BKSP) begin
        for (int i = 0; i < NUM_DIGITS - 1; i++) chars_d[i] = chars_q[i+1];
        chars_d[NUM_DIGITS-1] = SPACE;
      end else begin
        for (int i = 1; i < NUM_DIGITS; i++) chars_d[i] = chars_q[i-1];
        chars_d[0] = key_code;
      end
    end
  end

  always_comb begin
    slot_end = (cnt_q == CW'(DIGIT_CYCLES - 1));
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

`ifdef SEVENSEG_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = (bcnt_q == BW'(BLINK_CYCLES - 1)) ? '0 : bcnt_q + 1'b1;
    phase_d = phase_q ^ (bcnt_q == BW'(BLINK_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_off = blink & phase_q;
`else
  assign blink_off = 1'b0;
`endif

  // Anodes go dark for the first BLANK_CYCLES of each slot so the previous
  // digit's segments never ghost onto the next one.
  always_comb begin
    in_blank = (cnt_q < CW'(BLANK_CYCLES));
    an_d     = (in_blank || blink_off) ? '1 : ~(DIGIT0 << idx_q);
    seg_d    = in_blank ? SEG_OFF : decode(chars_q[idx_q]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) chars_q[i] <= SPACE;
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_OFF;
    end else begin
      chars_q <= chars_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_sevenseg_scroll_display.sv
// Bench for sevenseg_scroll_display: cycle-count based reference model plus directed literal checks.
module tb_sevenseg_scroll_display;
  localparam int N   = 4;
  localparam int DC  = 16;
  localparam int BL  = 2;
  localparam int BLK = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       clear;
  logic [N-1:0] an;
  logic [6:0] seg;
  logic       dp;
`ifdef SEVENSEG_BLINK_EN
  logic       blink;
`endif

  always #5 clk = ~clk;

  sevenseg_scroll_display #(
    .NUM_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BL), .BLINK_CYCLES(BLK)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .clear(clear),
`ifdef SEVENSEG_BLINK_EN
    .blink(blink),
`endif
    .an(an), .seg(seg), .dp(dp)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference glyph table, looked up by character (lowercase folded to uppercase).
  string      keys = "0123456789ABCDEFHLPU- ";
  logic [6:0] pats [22] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
                            7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h09, 7'h47, 7'h0C, 7'h41,
                            7'h3F, 7'h7F};

  function automatic logic [6:0] ref_seg(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    for (int i = 0; i < 22; i++) if (keys[i] == u) return pats[i];
    return 7'b0110110;
  endfunction

  // Model: a character array, plus edges counted since reset release.
  logic [7:0] mbuf  [N];
  logic [7:0] shown [N];
  int         edges;
  bit         blink_s;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edges <= 0;
      blink_s <= 1'b0;
      for (int i = 0; i < N; i++) begin
        mbuf[i]  <= 8'h20;
        shown[i] <= 8'h20;
      end
    end else begin
      edges <= edges + 1;
      shown <= mbuf;
`ifdef SEVENSEG_BLINK_EN
      blink_s <= blink;
`endif
      if (clear) begin
        for (int i = 0; i < N; i++) mbuf[i] <= 8'h20;
      end else if (key_valid) begin
        if (key_code == 8'h08) begin
          for (int i = 0; i < N - 1; i++) mbuf[i] <= mbuf[i+1];
          mbuf[N-1] <= 8'h20;
        end else begin
          for (int i = 1; i < N; i++) mbuf[i] <= mbuf[i-1];
          mbuf[0] <= key_code;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    int p, d;
    e_an = '1;
    e_seg = 7'h7F;
    if (!reset && edges > 0) begin
      p = (edges - 1) % DC;
      d = ((edges - 1) / DC) % N;
      if (p >= BL) begin
        e_an  = ~(N'(1) << d);
        e_seg = ref_seg(shown[d]);
      end
      if (blink_s && (((edges - 1) / BLK) % 2 == 1)) e_an = '1;
    end
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp", 32'(dp), 32'd1);
  end

  task automatic press(input logic [7:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic expect_digit(input logic [N-1:0] target, input logic [6:0] exp_seg,
                              input string name);
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (an !== target && t < 100);
    if (an !== target) chk({name, "_timeout"}, 32'(an), 32'(target));
    else chk(name, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    logic [N-1:0] seq [$];
    logic [N-1:0] last;
    int blanks, badseg;
    string s;
    reset = 1'b1;
    key_valid = 1'b0;
    key_code = 8'h00;
    clear = 1'b0;
`ifdef SEVENSEG_BLINK_EN
    blink = 1'b0;
`endif
    // 1: reset state, then two blank outputs before digit 0 lights
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rel0_an", 32'(an), 32'hF);
    @(negedge clk); #1 chk("rel1_an", 32'(an), 32'hF);
    @(negedge clk); #1 chk("rel2_an", 32'(an), 32'hF);
    @(negedge clk); #1 chk("rel3_an", 32'(an), 32'hE);

    // 2: idle scan order and blanking duty
    last = '1;
    blanks = 0;
    badseg = 0;
    seq.push_back(an);
    last = an;
    for (int k = 0; k < 77; k++) begin
      @(negedge clk);
      #1;
      if (an == '1) blanks++;
      else if (an != last) seq.push_back(an);
      if (an != '1) last = an;
      if (seg != 7'h7F) badseg++;
    end
    chk("idle_len", 32'(seq.size()), 32'd5);
    if (seq.size() == 5) begin
      chk("idle_s0", 32'(seq[0]), 32'hE);
      chk("idle_s1", 32'(seq[1]), 32'hD);
      chk("idle_s2", 32'(seq[2]), 32'hB);
      chk("idle_s3", 32'(seq[3]), 32'h7);
      chk("idle_s4", 32'(seq[4]), 32'hE);
    end
    chk("idle_blanks", 32'(blanks), 32'd8);
    chk("idle_seg", 32'(badseg), 32'd0);

    // 3: two keys
    press(8'h31);
    press(8'h30);
    expect_digit(4'hE, 7'b1000000, "k2_d0");
    expect_digit(4'hD, 7'b1111001, "k2_d1");
    expect_digit(4'hB, 7'h7F, "k2_d2");
    expect_digit(4'h7, 7'h7F, "k2_d3");

    // 4: overflow drops oldest, then backspace
    for (int k = 0; k < 5; k++) press(8'h31 + 8'(k));
    expect_digit(4'h7, 7'h24, "k5_d3");
    expect_digit(4'hB, 7'h30, "k5_d2");
    expect_digit(4'hD, 7'h19, "k5_d1");
    expect_digit(4'hE, 7'h12, "k5_d0");
    press(8'h08);
    expect_digit(4'h7, 7'h7F, "bs_d3");
    expect_digit(4'hB, 7'h24, "bs_d2");
    expect_digit(4'hD, 7'h30, "bs_d1");
    expect_digit(4'hE, 7'h19, "bs_d0");

    // 5: clear beats key, then an unmapped code
    @(negedge clk);
    clear = 1'b1;
    key_valid = 1'b1;
    key_code = 8'h39;
    @(negedge clk);
    clear = 1'b0;
    key_valid = 1'b0;
    expect_digit(4'hE, 7'h7F, "clr_d0");
    expect_digit(4'hD, 7'h7F, "clr_d1");
    expect_digit(4'hB, 7'h7F, "clr_d2");
    expect_digit(4'h7, 7'h7F, "clr_d3");
    press(8'h7E);
    expect_digit(4'hE, 7'b0110110, "tilde_d0");

    // glyph coverage through the model
    s = "aBcDeFhLpU-9876xyz";
    for (int k = 0; k < s.len(); k++) begin
      press(s[k]);
      if (k % 4 == 3) repeat (DC * N) @(negedge clk);
    end
    repeat (DC * N) @(negedge clk);

    // 6: async reset mid-slot at digit 2
    expect_digit(4'hB, ref_seg(mbuf[2]), "pre_rst_d2");
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1 chk("post1_an", 32'(an), 32'hF);
    @(negedge clk); #1 chk("post2_an", 32'(an), 32'hF);
    @(negedge clk); #1 chk("post3_an", 32'(an), 32'hE);
    chk("post3_seg", 32'(seg), 32'h7F);
    expect_digit(4'hD, 7'h7F, "post_d1");
    expect_digit(4'hB, 7'h7F, "post_d2");
    expect_digit(4'h7, 7'h7F, "post_d3");

`ifdef SEVENSEG_BLINK_EN
    // 7: blink blanking follows the free-running phase; the model checks every cycle
    @(negedge clk);
    blink = 1'b1;
    blanks = 0;
    repeat (4 * BLK) begin
      @(negedge clk);
      #1;
      if (an == '1) blanks++;
    end
    blink = 1'b0;
    chk("blink_min_dark", 32'(blanks >= 2 * BLK), 32'd1);
    repeat (DC * N) @(negedge clk);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
